fifo_reader: RTL and testbench

Read-side master for the synchronous 8-bit FIFO. On a `start` command it pops exactly `burst_len` words through the FIFO's `rd_en`/`out`/`empty` port, absorbing the FIFO's one-cycle read latency. It presents the words on a valid/ready stream with `m_last` on the final word. It pairs with the FIFO write-side producers: it is the consumer end that the existing push stimulus has been standing in for.

---
 rtl/fifo_reader.sv | 80 ++++++++
 tb/tb_fifo_reader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: pops a burst of words from a synchronous FIFO and streams them out on valid/ready.
module fifo_reader #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic              fifo_rd_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_out,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] issue_cnt_q, issue_cnt_d, accept_cnt_q, accept_cnt_d;
  logic [1:0] count_q, count_d;
  logic inflight_q, inflight_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];
  logic accept, pop;
  always_comb begin
    accept = m_valid && m_ready;
    // a slot must be free once in-flight words land, counting the word leaving this cycle
    pop = (state_q == READ) && !fifo_empty && (issue_cnt_q != '0) &&
          ({1'b0, count_q} + {2'b0, inflight_q} < 3'd2 + {2'b0, accept});
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q - LEN_W'(pop);
    accept_cnt_d = accept_cnt_q - LEN_W'(accept);
    case (state_q)
      IDLE: if (start) begin
        issue_cnt_d  = burst_len;
        accept_cnt_d = burst_len;
        state_d      = (burst_len == '0) ? DONE : READ;
      end
      READ:    state_d = (pop && issue_cnt_q == LEN_W'(1)) ? DRAIN : READ;
      DRAIN:   state_d = (accept && accept_cnt_q == LEN_W'(1)) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
    inflight_d = pop;
    count_d    = count_q + {1'b0, inflight_q} - {1'b0, accept};
    wr_ptr_d   = wr_ptr_q ^ inflight_q;
    rd_ptr_d   = rd_ptr_q ^ accept;
    buf_d      = buf_q;
    if (inflight_q) buf_d[wr_ptr_q] = fifo_out;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      issue_cnt_q  <= '0;
      accept_cnt_q <= '0;
      count_q      <= '0;
      inflight_q   <= 1'b0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      buf_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      accept_cnt_q <= accept_cnt_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      buf_q        <= buf_d;
    end
  end
  assign busy       = (state_q == READ) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign fifo_rd_en = pop;
  assign m_valid    = (count_q != '0);
  assign m_data     = buf_q[rd_ptr_q];
  assign m_last     = m_valid && (accept_cnt_q == LEN_W'(1));
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed vectors and burst sequences for fifo_reader against a behavioural FIFO.
module tb_fifo_reader;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, m_ready = 1'b1;
  logic [7:0] burst_len = 8'd0;
  logic busy, done, fifo_rd_en, fifo_empty, m_valid, m_last;
  logic [7:0] fifo_out = 8'd0, m_data;
  logic push_en = 1'b0, fifo_clr = 1'b0, toggle_en = 1'b0;
  logic [7:0] push_data = 8'd0;
  logic [7:0] mem [64];
  int wp = 0, rp = 0;
  int checks = 0, errors = 0;
  int pops, accs, dones, maxo;
  logic busy_bad, prev_stall = 1'b0, pl;
  logic [7:0] pd;
  logic [7:0] got [$];
  logic lasts [$];

  fifo_reader #(.DATA_W(8), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .busy(busy), .done(done),
    .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty), .fifo_out(fifo_out),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready));

  always #5 clk = ~clk;

  assign fifo_empty = (wp == rp);
  always @(posedge clk) begin
    if (fifo_clr) begin
      wp <= 0;
      rp <= 0;
    end else begin
      if (push_en) begin
        mem[wp % 64] <= push_data;
        wp <= wp + 1;
      end
      if (fifo_rd_en && !fifo_empty) begin
        fifo_out <= mem[rp % 64];
        rp <= rp + 1;
      end
    end
  end

  always @(negedge clk) if (toggle_en) m_ready = !m_ready;

  function automatic void chk(input string nm, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endfunction

  always begin
    @(negedge clk);
    #2;
    if (!rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", int'(m_valid), 1);
        chk("hold_data", int'(m_data), int'(pd));
        chk("hold_last", int'(m_last), int'(pl));
      end
      if (fifo_rd_en) pops++;
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        lasts.push_back(m_last);
        accs++;
      end
      if (pops - accs > maxo) maxo = pops - accs;
      if (done) dones++;
      prev_stall = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
    end
  end

  task automatic clear_mon();
    got.delete();
    lasts.delete();
    pops = 0; accs = 0; dones = 0; maxo = 0; busy_bad = 1'b0;
  endtask

  task automatic clear_fifo();
    @(negedge clk); fifo_clr = 1'b1;
    @(negedge clk); fifo_clr = 1'b0;
  endtask

  task automatic fill(input int first, input int step, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      push_en = 1'b1;
      push_data = 8'(first + i * step);
    end
    @(negedge clk);
    push_en = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    @(negedge clk);
    start = 1'b1;
    burst_len = 8'(len);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int limit);
    int n;
    for (n = 0; n < limit; n++) begin
      #1;
      if (done) break;
      if (!busy) busy_bad = 1'b1;
      @(negedge clk);
    end
    chk({nm, "_timeout"}, int'(n < limit), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_seq(input string nm, input int first, input int step, input int n);
    chk({nm, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      chk({nm, "_data"}, int'(got[i]), (first + i * step) & 255);
      chk({nm, "_last"}, int'(lasts[i]), int'(i == n - 1));
    end
  endtask

  typedef struct {
    logic st; logic [7:0] len; logic rdy;
    logic busy; logic done; logic rd; logic vld; logic [7:0] data; logic last;
  } vec_t;
  vec_t tbl [12];

  initial begin
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(fifo_rd_en), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_last", int'(m_last), 0);
    chk("rst_data", int'(m_data), 0);
    @(negedge clk); rst = 1'b1;
    // basic 4-word burst then a zero-length burst, cycle by cycle
    tbl[0]  = '{1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[1]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0};
    tbl[2]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0};
    tbl[3]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0};
    tbl[4]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0};
    tbl[5]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0};
    tbl[6]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4, 1'b1};
    tbl[7]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[8]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[9]  = '{1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[10] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[11] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    fill(1, 1, 4);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start = tbl[i].st;
      burst_len = tbl[i].len;
      m_ready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_busy", i), int'(busy), int'(tbl[i].busy));
      chk($sformatf("v%0d_done", i), int'(done), int'(tbl[i].done));
      chk($sformatf("v%0d_rd_en", i), int'(fifo_rd_en), int'(tbl[i].rd));
      chk($sformatf("v%0d_valid", i), int'(m_valid), int'(tbl[i].vld));
      if (tbl[i].vld) chk($sformatf("v%0d_data", i), int'(m_data), int'(tbl[i].data));
      chk($sformatf("v%0d_last", i), int'(m_last), int'(tbl[i].last));
    end
    chk("basic_fifo_left", wp - rp, 0);

    // backpressure: ready toggles every cycle
    fill(10, 10, 6);
    clear_mon();
    toggle_en = 1'b1;
    pulse_start(6);
    wait_done("bp", 80);
    toggle_en = 1'b0;
    m_ready = 1'b1;
    check_seq("bp", 10, 10, 6);
    chk("bp_outstanding", int'(maxo <= 2), 1);
    chk("bp_pops", pops, 6);
    chk("bp_dones", dones, 1);

    // starvation: only 2 words present, 3 more arrive later
    fill(33, 1, 2);
    clear_mon();
    fork
      begin
        repeat (5) @(negedge clk);
        fill(35, 1, 3);
      end
    join_none
    pulse_start(5);
    wait_done("starve", 80);
    check_seq("starve", 33, 1, 5);
    chk("starve_busy_held", int'(busy_bad), 0);
    chk("starve_pops", pops, 5);
    chk("starve_dones", dones, 1);

    // reset mid-burst after 3 accepts
    fill(129, 1, 8);
    clear_mon();
    pulse_start(8);
    for (int n = 0; n < 40 && accs < 3; n++) @(negedge clk) #3;
    chk("rstmid_accs", accs, 3);
    rst = 1'b0;
    #1;
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_done", int'(done), 0);
    chk("rstmid_rd_en", int'(fifo_rd_en), 0);
    chk("rstmid_valid", int'(m_valid), 0);
    chk("rstmid_last", int'(m_last), 0);
    chk("rstmid_data", int'(m_data), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstmid_no_done", dones, 0);
    chk("rstmid_idle", int'(busy), 0);
    clear_fifo();
    fill(7, 1, 3);
    clear_mon();
    pulse_start(3);
    wait_done("after_rst", 40);
    check_seq("after_rst", 7, 1, 3);
    chk("after_rst_pops", pops, 3);

    // second start during a burst is ignored
    fill(1, 1, 7);
    clear_mon();
    pulse_start(4);
    start = 1'b1;
    burst_len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done("sbusy", 40);
    repeat (5) @(negedge clk);
    check_seq("sbusy", 1, 1, 4);
    chk("sbusy_pops", pops, 4);
    chk("sbusy_dones", dones, 1);
    chk("sbusy_fifo_left", wp - rp, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
